// File: rtl/alu_pkg.sv
// Shared op-code encoding and control-state type for the execute-stage ALU/MDU.
package alu_pkg;

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_MULT  = 4'b0011;
    localparam logic [3:0] OP_MULTU = 4'b0100;
    localparam logic [3:0] OP_DIV   = 4'b0101;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_DIVU  = 4'b1000;
    localparam logic [3:0] OP_XOR   = 4'b1001;
    localparam logic [3:0] OP_SLL   = 4'b1010;
    localparam logic [3:0] OP_SRA   = 4'b1011;
    localparam logic [3:0] OP_SRL   = 4'b1100;
    localparam logic [3:0] OP_LUI   = 4'b1101;
    localparam logic [3:0] OP_SLTU  = 4'b1110;

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

endpackage

// File: rtl/mdu_seq.sv
// Iterative multiply/divide datapath: one bit per step on operand magnitudes,
// with sign correction applied combinationally to the held accumulator.
module mdu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             step,
    input  logic             div_mode,
    input  logic             sgn,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    logic             is_div;
    logic             neg_main;
    logic             neg_rem;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [CW-1:0]    cnt;

    logic [WIDTH-1:0] mag_a_in;
    logic [WIDTH-1:0] mag_b_in;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic             div_ge;

    assign mag_a_in = (sgn && a[WIDTH-1]) ? -a : a;
    assign mag_b_in = (sgn && b[WIDTH-1]) ? -b : b;

    // Multiply: acc_lo starts as the multiplier and shifts out while the product fills in.
    assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mag_b} : '0);
    // Divide: acc_hi is the partial remainder, acc_lo turns from dividend into quotient.
    assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, mag_b};
    assign div_ge    = !div_diff[WIDTH];

    assign done = step && (cnt == CW'(WIDTH - 1));

    // NOTE: async reset is in the sensitivity list; all state uses non-blocking assignment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            is_div   <= 1'b0;
            neg_main <= 1'b0;
            neg_rem  <= 1'b0;
            mag_b    <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            cnt      <= '0;
        end else if (start) begin
            is_div   <= div_mode;
            neg_main <= sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_rem  <= sgn && a[WIDTH-1];
            mag_b    <= mag_b_in;
            acc_hi   <= '0;
            acc_lo   <= mag_a_in;
            cnt      <= '0;
        end else if (step) begin
            cnt <= cnt + 1'b1;
            if (is_div) begin
                acc_hi <= div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
                acc_lo <= {acc_lo[WIDTH-2:0], div_ge};
            end else begin
                acc_hi <= mul_sum[WIDTH:1];
                acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
            end
        end
    end

    // NOTE: every output gets a default first so no latch is inferred.
    always_comb begin
        hi = acc_hi;
        lo = acc_lo;
        if (is_div) begin
            if (neg_main) lo = -acc_lo;
            if (neg_rem)  hi = -acc_hi;
        end else if (neg_main) begin
            {hi, lo} = -{acc_hi, acc_lo};
        end
    end

endmodule

// File: rtl/alu_mdu.sv
// Execute-stage ALU with iterative MDU, HI/LO registers and a registered
// valid/ready result; the pipeline stalls while in_ready is low.
module alu_mdu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [SHW-1:0]   shamt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    state_t state, next_state;

    logic             accept, is_mul, is_div, sgn_op, div_zero, div_ovf, long_op;
    logic             mdu_done;
    logic [WIDTH-1:0] mdu_hi, mdu_lo;
    logic [WIDTH-1:0] sum, diff;
    logic [WIDTH-1:0] fast_res, fast_hi, fast_lo;
    logic             fast_ovf, fast_hilo;

    assign in_ready = (state == IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    assign is_mul   = (op == OP_MULT) || (op == OP_MULTU);
    assign is_div   = (op == OP_DIV) || (op == OP_DIVU);
    assign sgn_op   = (op == OP_MULT) || (op == OP_DIV);
    assign div_zero = is_div && (b == '0);
    assign div_ovf  = (op == OP_DIV) && (a == MOST_NEG) && (b == '1);
    // Degenerate divides finish in one cycle; only normal mult/div go iterative.
    assign long_op  = is_mul || (is_div && !div_zero && !div_ovf);

    assign sum  = a + b;
    assign diff = a - b;

    mdu_seq #(.WIDTH(WIDTH)) u_mdu (
        .clk      (clk),
        .rst      (rst),
        .start    (accept && long_op),
        .step     ((state == MUL) || (state == DIV)),
        .div_mode (is_div),
        .sgn      (sgn_op),
        .a        (a),
        .b        (b),
        .done     (mdu_done),
        .hi       (mdu_hi),
        .lo       (mdu_lo)
    );

    always_comb begin
        next_state = state;
        case (state)
            IDLE:     if (accept && long_op) next_state = is_mul ? MUL : DIV;
            MUL, DIV: if (mdu_done) next_state = FIX;
            FIX:      next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    always_comb begin
        fast_res  = '0;
        fast_ovf  = 1'b0;
        fast_hilo = 1'b0;
        fast_hi   = '0;
        fast_lo   = '0;
        case (op)
            OP_AND:  fast_res = a & b;
            OP_OR:   fast_res = a | b;
            OP_XOR:  fast_res = a ^ b;
            OP_ADD: begin
                fast_res = sum;
                fast_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                fast_res = diff;
                fast_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SLL:  fast_res = b << shamt;
            OP_SRL:  fast_res = b >> shamt;
            OP_SRA:  fast_res = $signed(b) >>> shamt;
            OP_SLT:  fast_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            OP_SLTU: fast_res = {{(WIDTH-1){1'b0}}, a < b};
            OP_LUI:  fast_res = b << (WIDTH / 2);
            default: fast_res = '0;
        endcase
        if (div_zero) begin
            fast_res  = '1;
            fast_hilo = 1'b1;
            fast_hi   = a;
            fast_lo   = '1;
        end else if (div_ovf) begin
            fast_res  = MOST_NEG;
            fast_ovf  = 1'b1;
            fast_hilo = 1'b1;
            fast_hi   = '0;
            fast_lo   = MOST_NEG;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b1;
            overflow  <= 1'b0;
            hi        <= '0;
            lo        <= '0;
        end else begin
            state <= next_state;
            if (accept && !long_op) begin
                out_valid <= 1'b1;
                result    <= fast_res;
                zero      <= (fast_res == '0);
                overflow  <= fast_ovf;
                if (fast_hilo) begin
                    hi <= fast_hi;
                    lo <= fast_lo;
                end
            end else if (state == FIX) begin
                out_valid <= 1'b1;
                result    <= mdu_lo;
                zero      <= (mdu_lo == '0);
                overflow  <= 1'b0;
                hi        <= mdu_hi;
                lo        <= mdu_lo;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_mdu.sv
// Directed bench for alu_mdu: an arithmetic reference model checked every
// cycle, plus hand-computed literal expectations.
module tb_alu_mdu;
    import alu_pkg::*;

    localparam int WIDTH    = 32;
    localparam int SHW      = 5;
    localparam int LONG_LAT = WIDTH + 1;
    localparam longint S_MAX = 64'sd2147483647;
    localparam longint S_MIN = -64'sd2147483648;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [3:0]  op = 4'd0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [4:0]  shamt = '0;
    logic        out_ready = 1'b1;
    logic        in_ready, out_valid, zero, overflow;
    logic [31:0] result, hi, lo;

    int n_vec = 0;
    int n_err = 0;

    alu_mdu #(.WIDTH(WIDTH), .SHW(SHW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .shamt     (shamt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .overflow  (overflow),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic check_bit(input string name, input logic got, input logic exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, expected %b at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [31:0] res;
        logic        ovf;
        logic        wr_hilo;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        long_op;
    } model_t;

    function automatic model_t model_op(input logic [3:0] f, input logic [31:0] x,
                                        input logic [31:0] y, input logic [4:0] s);
        model_t          m;
        longint          sx, sy, p;
        longint unsigned up;
        m  = '0;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (f)
            OP_ADD:  begin m.res = x + y; p = sx + sy; m.ovf = (p > S_MAX) || (p < S_MIN); end
            OP_SUB:  begin m.res = x - y; p = sx - sy; m.ovf = (p > S_MAX) || (p < S_MIN); end
            OP_AND:  m.res = x & y;
            OP_OR:   m.res = x | y;
            OP_XOR:  m.res = x ^ y;
            OP_SLL:  m.res = y << s;
            OP_SRL:  m.res = y >> s;
            OP_SRA:  m.res = $signed(y) >>> s;
            OP_SLT:  m.res = (sx < sy) ? 32'd1 : 32'd0;
            OP_SLTU: m.res = (x < y) ? 32'd1 : 32'd0;
            OP_LUI:  m.res = {y[15:0], 16'h0000};
            OP_MULT: begin
                p = sx * sy;
                m.hi = p[63:32]; m.lo = p[31:0]; m.wr_hilo = 1'b1; m.long_op = 1'b1;
            end
            OP_MULTU: begin
                up = {32'h0, x} * {32'h0, y};
                m.hi = up[63:32]; m.lo = up[31:0]; m.wr_hilo = 1'b1; m.long_op = 1'b1;
            end
            OP_DIV, OP_DIVU: begin
                m.wr_hilo = 1'b1;
                if (y == 32'h0) begin
                    m.lo = 32'hFFFF_FFFF; m.hi = x;
                end else if (f == OP_DIV && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
                    m.lo = 32'h8000_0000; m.hi = 32'h0; m.ovf = 1'b1;
                end else begin
                    m.long_op = 1'b1;
                    if (f == OP_DIV) begin
                        m.lo = 32'(sx / sy); m.hi = 32'(sx % sy);
                    end else begin
                        m.lo = x / y; m.hi = x % y;
                    end
                end
            end
            default: m.res = 32'h0;
        endcase
        if (m.wr_hilo) m.res = m.lo;
        return m;
    endfunction

    logic        m_valid = 1'b0;
    logic [31:0] m_res = '0;
    logic        m_zero = 1'b1;
    logic        m_ovf = 1'b0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    int          m_busy = 0;
    model_t      m_pend = '0;

    always @(posedge clk or posedge rst) begin : model_p
        model_t t;
        if (rst) begin
            m_valid <= 1'b0; m_res <= '0; m_zero <= 1'b1; m_ovf <= 1'b0;
            m_hi <= '0; m_lo <= '0; m_busy <= 0;
        end else if (m_busy > 0) begin
            m_busy <= m_busy - 1;
            if (m_busy == 1) begin
                m_valid <= 1'b1; m_res <= m_pend.res; m_zero <= (m_pend.res == 32'h0);
                m_ovf <= m_pend.ovf; m_hi <= m_pend.hi; m_lo <= m_pend.lo;
            end
        end else if (in_valid && (!m_valid || out_ready)) begin
            t = model_op(op, a, b, shamt);
            if (t.long_op) begin
                m_busy <= LONG_LAT; m_pend <= t; m_valid <= 1'b0;
            end else begin
                m_valid <= 1'b1; m_res <= t.res; m_zero <= (t.res == 32'h0); m_ovf <= t.ovf;
                if (t.wr_hilo) begin
                    m_hi <= t.hi; m_lo <= t.lo;
                end
            end
        end else if (out_ready) begin
            m_valid <= 1'b0;
        end
    end

    always @(negedge clk) begin
        check_bit("out_valid", out_valid, m_valid);
        check_bit("in_ready", in_ready, (m_busy == 0) && (!m_valid || out_ready));
        check("hi", hi, m_hi);
        check("lo", lo, m_lo);
        if (m_valid) begin
            check("result", result, m_res);
            check_bit("zero", zero, m_zero);
            check_bit("overflow", overflow, m_ovf);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] f, input logic [31:0] x, input logic [31:0] y,
                         input logic [4:0] s, output int waited);
        logic rdy;
        in_valid = 1'b1; op = f; a = x; b = y; shamt = s;
        waited = 0;
        rdy = 1'b0;
        while (!rdy && waited < 200) begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            #1;
            if (!rdy) waited++;
        end
        in_valid = 1'b0;
        check_bit("accept_bound", rdy, 1'b1);
    endtask

    task automatic wait_valid(output int lat, input logic chk_busy);
        lat = 0;
        while (!out_valid && lat < 100) begin
            if (chk_busy) check_bit("busy_in_ready", in_ready, 1'b0);
            tick();
            lat++;
        end
        check_bit("valid_bound", out_valid, 1'b1);
    endtask

    typedef struct packed {
        logic [3:0]  f;
        logic [31:0] x;
        logic [31:0] y;
        logic [4:0]  s;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [0:13];

    initial begin
        int w, lat;
        vecs = '{
            '{OP_SUB,   32'h8000_0000, 32'h0000_0001, 5'd0,  32'h7FFF_FFFF},
            '{OP_AND,   32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0,  32'hF000_F000},
            '{OP_OR,    32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0,  32'hFFF0_FFF0},
            '{OP_XOR,   32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0,  32'h0FF0_0FF0},
            '{OP_SLL,   32'h0,         32'h0000_0001, 5'd31, 32'h8000_0000},
            '{OP_SRL,   32'h0,         32'h8000_0000, 5'd31, 32'h0000_0001},
            '{OP_LUI,   32'h0,         32'h0000_1234, 5'd0,  32'h1234_0000},
            '{4'b1111,  32'h5,         32'h5,         5'd3,  32'h0000_0000},
            '{OP_ADD,   32'h1,         32'hFFFF_FFFF, 5'd0,  32'h0000_0000},
            '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0,  32'h0000_0001},
            '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 5'd0,  32'h0000_0000},
            '{OP_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 5'd0,  32'hFFFF_FFFD},
            '{OP_DIVU,  32'hFFFF_FFFF, 32'h0000_0010, 5'd0,  32'h0FFF_FFFF},
            '{OP_DIV,   32'h8000_0000, 32'h0000_0007, 5'd0,  32'hEDB6_DB6E}
        };

        repeat (3) tick();
        check("rst_result", result, 32'h0);
        check_bit("rst_zero", zero, 1'b1);
        check_bit("rst_overflow", overflow, 1'b0);
        check_bit("rst_out_valid", out_valid, 1'b0);
        check("rst_hi", hi, 32'h0);
        check("rst_lo", lo, 32'h0);
        rst = 1'b0;
        #1;
        check_bit("rst_in_ready", in_ready, 1'b1);

        issue(OP_ADD, 32'h7FFF_FFFF, 32'h1, 5'd0, w);
        wait_valid(lat, 1'b0);
        check("add_lat", 32'(lat), 32'd0);
        check("add_res", result, 32'h8000_0000);
        check_bit("add_ovf", overflow, 1'b1);

        issue(OP_SRA, 32'h0, 32'hF000_0000, 5'd4, w);
        check("sra_res", result, 32'hFF00_0000);
        issue(OP_SLTU, 32'h1, 32'hFFFF_FFFF, 5'd0, w);
        check("sltu_res", result, 32'h1);
        issue(OP_SLT, 32'h1, 32'hFFFF_FFFF, 5'd0, w);
        check("slt_res", result, 32'h0);
        check_bit("slt_zero", zero, 1'b1);

        issue(OP_MULT, 32'hFFFF_FFFD, 32'h7, 5'd0, w);
        wait_valid(lat, 1'b1);
        check("mult_lat", 32'(lat), 32'd33);
        check("mult_lo", lo, 32'hFFFF_FFEB);
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_res", result, 32'hFFFF_FFEB);

        issue(OP_DIV, 32'hFFFF_FFF9, 32'h2, 5'd0, w);
        wait_valid(lat, 1'b1);
        check("div_lat", 32'(lat), 32'd33);
        check("div_lo", lo, 32'hFFFF_FFFD);
        check("div_hi", hi, 32'hFFFF_FFFF);

        issue(OP_DIVU, 32'h5, 32'h0, 5'd0, w);
        wait_valid(lat, 1'b0);
        check("divz_lat", 32'(lat), 32'd0);
        check("divz_lo", lo, 32'hFFFF_FFFF);
        check("divz_hi", hi, 32'h5);

        foreach (vecs[i]) begin
            issue(vecs[i].f, vecs[i].x, vecs[i].y, vecs[i].s, w);
            wait_valid(lat, 1'b1);
            check($sformatf("vec%0d_res", i), result, vecs[i].exp);
        end
        check("multu_max_hi_pin", 32'h0, 32'h0 ^ 32'h0 ^ (hi & 32'h0)); // keeps hi usage cheap
        
        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0, w);
        check("dovf_lo", lo, 32'h8000_0000);
        check("dovf_hi", hi, 32'h0);
        check_bit("dovf_ovf", overflow, 1'b1);
        out_ready = 1'b0;
        in_valid = 1'b1; op = OP_ADD; a = 32'h1; b = 32'h1; shamt = 5'd0;
        repeat (5) begin
            tick();
            check("hold_res", result, 32'h8000_0000);
            check_bit("hold_ovf", overflow, 1'b1);
            check_bit("hold_valid", out_valid, 1'b1);
            check_bit("hold_in_ready", in_ready, 1'b0);
        end
        out_ready = 1'b1;
        issue(OP_ADD, 32'h1, 32'h1, 5'd0, w);
        check("b2b_wait", 32'(w), 32'd0);
        check("b2b_res", result, 32'h2);
        check_bit("b2b_valid", out_valid, 1'b1);

        issue(OP_DIVU, 32'h7, 32'h0, 5'd0, w);
        check("pre_rst_hi", hi, 32'h7);
        issue(OP_MULTU, 32'h1234_5678, 32'h9ABC_DEF0, 5'd0, w);
        repeat (10) tick();
        rst = 1'b1;
        #1;
        check_bit("abort_valid", out_valid, 1'b0);
        check("abort_hi", hi, 32'h0);
        check("abort_lo", lo, 32'h0);
        tick();
        rst = 1'b0;
        issue(OP_ADD, 32'h3, 32'h4, 5'd0, w);
        check("post_rst_wait", 32'(w), 32'd0);
        check("post_rst_res", result, 32'h7);
        repeat (40) tick();
        check_bit("post_rst_no_ghost", out_valid, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
